ising_phase_reader: RTL
=======================

Name: ising_phase_reader

Overview:
- Readout counterpart to the weight-write path of the coupled oscillator array.
- Samples the asynchronous oscillator phase outputs of the NxN array against a reference oscillator.
- Accumulates per-spin mismatch counts over a programmable window and resolves a spin vector.
- Exposes status, spins and counts through a synchronous AXI-side read interface, in the same clock domain as weight programming.

Parameters:
- NUM_SPINS, 8, number of oscillator phase inputs sampled; 1..31.
- SYNC_STAGES, 2, flip-flop synchronizer depth per async input; >=2.
- CNT_WIDTH, 16, width of the window length and of each mismatch counter.

Ports:
- clk  input  1  AXI-side clock; all logic on posedge.
- axi_rst  input  1  reset, asynchronous assert, active-high.
- phase_in  input  NUM_SPINS  async oscillator outputs, one per spin.
- phase_ref  input  1  async reference oscillator output.
- start  input  1  single-cycle pulse; begins a measurement.
- settle_len  input  CNT_WIDTH  cycles to wait before sampling.
- window_len  input  CNT_WIDTH  number of sample cycles.
- rready  input  1  read request strobe.
- rd_addr_match  input  1  read address decodes to this block.
- rd_index  input  8  word select.
- rdata  output  32  read data.
- rvalid  output  1  rdata valid.
- busy  output  1  measurement in progress.
- done  output  1  results valid, sticky.

Behaviour:
- Reset: all synchronizers, counters, spin vector, rdata, rvalid, busy and done are 0. The FSM enters IDLE.
- Synchronization:
  - phase_in and phase_ref each pass through SYNC_STAGES flops.
  - mismatch[i] = sync_in[i] ^ sync_ref, computed from synchronized values only.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start, latch settle_len into settle_cnt and window_len into win_cnt.
  - Clear all mismatch counters and done. Set busy.
  - Go to SETTLE, or to SAMPLE directly if settle_len==0.
  - If window_len==0, go straight to DONE with spins=0, counts=0 and done=1 on the next cycle.
- SETTLE:
  - Decrement settle_cnt each cycle.
  - Enter SAMPLE on the cycle after settle_cnt reaches 1.
  - Exactly settle_len cycles are spent in SETTLE.
- SAMPLE:
  - Each cycle, for every i, cnt[i] += mismatch[i]. Counters saturate at all-ones and never wrap.
  - Decrement win_cnt. After exactly window_len sample cycles, go to DONE.
- DONE (entered from SAMPLE):
  - spin[i] = (cnt[i] > window_len_latched>>1), with strict greater-than. A tie resolves to 0.
  - done=1, busy=0. Go to IDLE on the same transition; done remains set.
- start while busy is ignored. start in IDLE with done=1 clears done and restarts.
- Read interface:
  - When rready & rd_addr_match, on the next cycle rdata and rvalid=1 are presented for one cycle. Read latency is 1.
  - rvalid=0 and rdata=0 otherwise.
  - Index 0: {29'b0, state[1:0] encoded IDLE=0/SETTLE=1/SAMPLE=2/DONE=3, done}. Bit0=done, bits2:1=state.
  - Index 1: spin vector, zero-extended to 32.
  - Any other index without the optional feature returns 0.
  - A read during a measurement returns the current (previous-result) spin register. Spin updates only on the DONE transition.
- Simultaneous events: a read coincident with the DONE transition returns the pre-update value.
- axi_rst mid-measurement aborts immediately to the reset state.

Optional Feature:
- Macro: PHASE_RAW_COUNT_EN.
- When defined:
  - Index 2+i (i < NUM_SPINS) returns cnt[i] zero-extended to 32. Counters hold their values after DONE until the next start.
  - Index 2+NUM_SPINS and above return 0.
- When undefined:
  - Counters remain internal.
  - Indices >= 2 return 0.
  - Counter state may be reduced to a per-spin comparator-only implementation, provided spin results are identical.

Test Plan:
- Reset mid-SAMPLE: assert axi_rst during SAMPLE -> busy=0, done=0, spin reads 0, index 0 reads 0x0.
- In-phase/anti-phase: NUM_SPINS=8, settle_len=4, window_len=100. phase_in[3:0] tied equal to phase_ref, phase_in[7:4] inverted -> done after 4+100 cycles plus sync delay. Index 1 reads 0x000000F0. With PHASE_RAW_COUNT_EN, index 6 reads 100 and index 2 reads 0.
- Tie: window_len=4, phase_in[0] mismatches for exactly 2 sampled cycles -> spin[0]=0. With 3 mismatching cycles -> spin[0]=1.
- Zero window: window_len=0, start -> done=1 next cycle, index 1 reads 0, busy never set beyond one cycle.
- start ignored while busy: second start pulse in SETTLE -> completion timing unchanged, results unchanged.
- Read timing: rready & rd_addr_match with rd_index=0 in IDLE after done -> rvalid=1 one cycle later, rdata=0x1. Without rd_addr_match -> rvalid stays 0.

Source files
------------

// File: rtl/ising_phase_reader.sv
// rtl/ising_phase_reader.sv - oscillator phase readout: sync, windowed mismatch count, spin resolve, register read
// Optional raw counter readback: define PHASE_RAW_COUNT_EN
module ising_phase_reader #(
  parameter int NUM_SPINS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 axi_rst,
  input  logic [NUM_SPINS-1:0] phase_in,
  input  logic                 phase_ref,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] settle_len,
  input  logic [CNT_WIDTH-1:0] window_len,
  input  logic                 rready,
  input  logic                 rd_addr_match,
  input  logic [7:0]           rd_index,
  output logic [31:0]          rdata,
  output logic                 rvalid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SPINS-1:0] sync_in_q  [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] sync_ref_q;
  logic [NUM_SPINS-1:0] mismatch;

  logic [CNT_WIDTH-1:0] settle_cnt_q;
  logic [CNT_WIDTH-1:0] win_cnt_q;
  logic [CNT_WIDTH-1:0] win_len_q;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_SPINS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_SPINS];
  logic [NUM_SPINS-1:0] spin_q, spin_d;
  logic                 busy_q, done_q;
  logic [31:0]          rdata_q;
  logic                 rvalid_q;
  logic [31:0]          rd_word;

  logic load_en, zero_win, sample_en, finish;
  logic rd_req;

  // Multi-flop synchronizers for the free-running oscillator outputs
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_in_q[s] <= '0;
      sync_ref_q <= '0;
    end else begin
      sync_in_q[0]  <= phase_in;
      sync_ref_q[0] <= phase_ref;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_in_q[s]  <= sync_in_q[s-1];
        sync_ref_q[s] <= sync_ref_q[s-1];
      end
    end
  end

  assign mismatch = sync_in_q[SYNC_STAGES-1] ^ {NUM_SPINS{sync_ref_q[SYNC_STAGES-1]}};

  // FSM state register
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic; DONE is a single-cycle state that falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (window_len == '0)      state_d = ST_DONE;
          else if (settle_len == '0) state_d = ST_SAMPLE;
          else                       state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: if (settle_cnt_q == CNT_WIDTH'(1)) state_d = ST_SAMPLE;
      ST_SAMPLE: if (win_cnt_q == CNT_WIDTH'(1))    state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output strobes driving the datapath
  always_comb begin
    load_en   = (state_q == ST_IDLE) && start;
    zero_win  = load_en && (window_len == '0);
    sample_en = (state_q == ST_SAMPLE);
    finish    = sample_en && (win_cnt_q == CNT_WIDTH'(1));
  end

  // Saturating counter increment and majority decision including the final sample
  always_comb begin
    for (int i = 0; i < NUM_SPINS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (mismatch[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      spin_d[i] = (cnt_d[i] > (win_len_q >> 1));
    end
  end

  // Measurement datapath: window counters, mismatch counters, spin and status registers
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      win_len_q    <= '0;
      for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= '0;
      spin_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (load_en) begin
        settle_cnt_q <= settle_len;
        win_cnt_q    <= window_len;
        win_len_q    <= window_len;
        for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= '0;
        // An empty window completes immediately with all-zero results
        busy_q       <= !zero_win;
        done_q       <= zero_win;
        if (zero_win) spin_q <= '0;
      end
      if (state_q == ST_SETTLE) settle_cnt_q <= settle_cnt_q - CNT_WIDTH'(1);
      if (sample_en) begin
        for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= cnt_d[i];
        win_cnt_q <= win_cnt_q - CNT_WIDTH'(1);
      end
      if (finish) begin
        spin_q <= spin_d;
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  // Read word mux over current register contents, so a coincident update is not visible
  always_comb begin
    rd_word = '0;
    if (rd_index == 8'd0)      rd_word = {29'b0, state_q, done_q};
    else if (rd_index == 8'd1) rd_word = {{(32-NUM_SPINS){1'b0}}, spin_q};
`ifdef PHASE_RAW_COUNT_EN
    else begin
      for (int i = 0; i < NUM_SPINS; i++) begin
        if (rd_index == 8'(i + 2)) rd_word = 32'(cnt_q[i]);
      end
    end
`endif
  end

  assign rd_req = rready & rd_addr_match;

  // One-cycle read response; data is forced to zero when not valid
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_req;
      rdata_q  <= rd_req ? rd_word : 32'h0;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
